delay_tap_mixer: RTL and testbench
==================================

# delay_tap_mixer

Downstream stage of the delay-line bank. It takes the dry input sample and the currently selected delayed tap (30/45/60/90 stages) and produces a rounded weighted echo mix through a 2-stage pipeline. It tracks tap selection changes and blanks the output's valid flag until the newly selected delay line has refilled with real data. Sits between the tap-select mux and `uo_out`.

## Interface
Parameters:
- `WIDTH`, 8: sample width.
- `DEPTH0`/`DEPTH1`/`DEPTH2`/`DEPTH3`, 30/45/60/90: latency in cycles of the delay line selected by `tap_sel` = 0/1/2/3.

Ports:
- `clk`  in  1: single clock; all state is updated on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: clock enable. Low freezes all state.
- `dry_in`  in  WIDTH: unsigned input sample, the same sample that feeds the delay lines.
- `tap_in`  in  WIDTH: unsigned output of the selected delay line.
- `tap_sel`  in  2: delay line selection. It also drives the external mux.
- `gain`  in  4: echo weight in eighths. Values above 8 clamp to 8.
- `mix_out`  out  WIDTH: mixed sample.
- `out_valid`  out  1: `mix_out` includes a fully settled tap.
- `settle_busy`  out  1: high while the selected delay line is refilling.

## Operation
- Registers:
  - `sel_q` (2 bits).
  - Fill counter `cnt`, wide enough for DEPTH3 (7 bits).
  - State `st` ∈ {FILL, RUN}.
  - Pipeline: stage-1 products plus valid, stage-2 result plus valid.
- Reset values:
  - `st`=FILL, `sel_q`=0, `cnt`=DEPTH0.
  - All pipeline registers 0.
  - Resulting outputs: `mix_out`=0, `out_valid`=0, `settle_busy`=1.
- Each cycle with `en`=1, with priority in this order:
  1. `tap_sel`≠`sel_q`: `sel_q`←`tap_sel`, `cnt`←DEPTH[`tap_sel`], `st`←FILL. This applies from either state.
  2. `st`=FILL and `cnt`==1: `st`←RUN.
  3. `st`=FILL otherwise: `cnt`←`cnt`−1.
  4. `st`=RUN: hold.
- FILL therefore lasts exactly DEPTH[`sel_q`] enabled cycles after the load cycle. A selection change mid-FILL restarts the count from the new depth.
- `settle_busy` = (`st`==FILL), driven directly from the state register.
- Effective gain `g`:
  - `g` = min(`gain`, 8) when `st`=RUN.
  - `g` = 0 when `st`=FILL, so the output is pure dry.
- Stage 1 (`en`=1): `p_dry`←`dry_in`·(8−`g`) and `p_tap`←`tap_in`·`g`, each 12 bits unsigned; `v1`←(`st`==RUN).
- Stage 2 (`en`=1): `mix_out`←(`p_dry`+`p_tap`+4)>>3; `out_valid`←`v1`.
  - The sum fits in 12 bits, since the maximum is 255·8+4 = 2044.
  - The result is ≤255, so no saturation is needed.
- `en`=0: nothing changes, including the counter, the pipeline and `sel_q`. Selection changes are detected only on enabled cycles.
- `rst` is asserted mid-operation: the next edge returns to the reset values regardless of `en`.

## Timing
- Data latency: 2 enabled cycles from `dry_in`/`tap_in` to `mix_out`.
- `settle_busy` changes on the same edge that updates `st`, with 0 cycles of pipeline lag.
- `out_valid` lags `settle_busy` by 2 enabled cycles:
  - It falls 2 cycles after a selection change is captured.
  - It rises 2 cycles after `st` enters RUN.
- The first enabled cycle after reset with `tap_sel`=2 counts as the load cycle. `settle_busy` then falls 60 enabled cycles later.
- `gain` and `tap_sel` are sampled only on enabled edges. They need no holding beyond one cycle.

## Structure
- Shared package `delay_line_pkg`:
  - `WIDTH`.
  - DEPTH0..3 constants and the depth lookup function.
  - Gain width and the clamp constant 8.
  - State enum {FILL, RUN}.
- Sub-module `mix_datapath`: the 2-stage multiply/add/round pipeline with its valid bit, taking `en`, `rst` and `g`.
- Top level: selection tracker FSM plus counter, with `mix_datapath` instantiated inside it.

## Test plan
- Reset, `tap_sel`=0, `en`=1, `gain`=8:
  - `settle_busy`=1 for 30 cycles, then 0.
  - `out_valid` rises 2 cycles later.
  - Then `mix_out` = `tap_in` with 2-cycle latency.
- In RUN, `gain`=4, `dry_in`=200, `tap_in`=101: `mix_out` = (800+404+4)>>3 = 151, 2 cycles later.
- `gain`=15 vs. `gain`=8 with the same inputs: identical outputs (clamp). `gain`=0 with `dry_in`=255: `mix_out`=255.
- In RUN, switch `tap_sel` 0→3:
  - `settle_busy`=1 immediately, for 90 enabled cycles.
  - `out_valid` drops 2 cycles after the switch.
  - `mix_out` = `dry_in` during FILL.
- Switch `tap_sel` 1→2 at FILL count 20: FILL restarts for a full 60 cycles.
- Hold `en`=0 for 10 cycles during FILL: counter and outputs frozen, total FILL extended by exactly 10 cycles. Assert `rst` mid-RUN: next cycle `mix_out`=0, `out_valid`=0, `settle_busy`=1.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared constants, state encoding and depth lookup for the delay-line bank.
package delay_line_pkg;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH0 = 30;
  localparam int unsigned DEPTH1 = 45;
  localparam int unsigned DEPTH2 = 60;
  localparam int unsigned DEPTH3 = 90;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned GAIN_W = 4;
  localparam logic [GAIN_W-1:0] GAIN_MAX = 4'd8;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [CNT_W-1:0] depth_lookup(
    input logic [1:0]  sel,
    input int unsigned d0,
    input int unsigned d1,
    input int unsigned d2,
    input int unsigned d3
  );
    logic [CNT_W-1:0] d;
    case (sel)
      2'd0:    d = CNT_W'(d0);
      2'd1:    d = CNT_W'(d1);
      2'd2:    d = CNT_W'(d2);
      default: d = CNT_W'(d3);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mix_datapath.sv
// Two-stage weighted dry/tap mix: multiply, then add with round-half-up and divide by 8.
module mix_datapath
  import delay_line_pkg::*;
#(
  parameter int unsigned DW = delay_line_pkg::WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DW-1:0]     dry_in,
  input  logic [DW-1:0]     tap_in,
  input  logic [GAIN_W-1:0] g,
  input  logic              run,
  output logic [DW-1:0]     mix_out,
  output logic              out_valid
);

  localparam int unsigned PROD_W = DW + 4;

  logic [PROD_W-1:0] p_dry_q, p_dry_d;
  logic [PROD_W-1:0] p_tap_q, p_tap_d;
  logic              v1_q, v1_d;
  logic [DW-1:0]     mix_q, mix_d;
  logic              v2_q, v2_d;
  logic [PROD_W-1:0] sum;

  always_comb begin
    p_dry_d = PROD_W'(dry_in) * PROD_W'(GAIN_MAX - g);
    p_tap_d = PROD_W'(tap_in) * PROD_W'(g);
    v1_d    = run;
    // Weights total 8, so the rounded sum never exceeds full scale.
    sum     = p_dry_q + p_tap_q + PROD_W'(4);
    mix_d   = DW'(sum >> 3);
    v2_d    = v1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_dry_q <= '0;
      p_tap_q <= '0;
      v1_q    <= 1'b0;
      mix_q   <= '0;
      v2_q    <= 1'b0;
    end else if (en) begin
      p_dry_q <= p_dry_d;
      p_tap_q <= p_tap_d;
      v1_q    <= v1_d;
      mix_q   <= mix_d;
      v2_q    <= v2_d;
    end
  end

  assign mix_out   = mix_q;
  assign out_valid = v2_q;

endmodule

// File: rtl/delay_tap_mixer.sv
// Echo mixer: tracks tap selection, blanks the echo while the new delay line refills.
module delay_tap_mixer #(
  parameter int unsigned WIDTH  = delay_line_pkg::WIDTH,
  parameter int unsigned DEPTH0 = delay_line_pkg::DEPTH0,
  parameter int unsigned DEPTH1 = delay_line_pkg::DEPTH1,
  parameter int unsigned DEPTH2 = delay_line_pkg::DEPTH2,
  parameter int unsigned DEPTH3 = delay_line_pkg::DEPTH3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] dry_in,
  input  logic [WIDTH-1:0] tap_in,
  input  logic [1:0]       tap_sel,
  input  logic [3:0]       gain,
  output logic [WIDTH-1:0] mix_out,
  output logic             out_valid,
  output logic             settle_busy
);

  import delay_line_pkg::*;

  state_e            st_q, st_d;
  logic [1:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAIN_W-1:0] g;
  logic              run;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= FILL;
      sel_q <= '0;
      cnt_q <= CNT_W'(DEPTH0);
    end else if (en) begin
      st_q  <= st_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  // A new selection reloads from either state; FILL ends on the cycle cnt reaches 1.
  always_comb begin
    st_d  = st_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    if (tap_sel != sel_q) begin
      sel_d = tap_sel;
      cnt_d = depth_lookup(tap_sel, DEPTH0, DEPTH1, DEPTH2, DEPTH3);
      st_d  = FILL;
    end else if (st_q == FILL) begin
      if (cnt_q == CNT_W'(1)) begin
        st_d = RUN;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    settle_busy = (st_q == FILL);
    run         = (st_q == RUN);
    g           = '0;
    if (st_q == RUN) begin
      g = (gain > GAIN_MAX) ? GAIN_MAX : gain;
    end
  end

  mix_datapath #(
    .DW(WIDTH)
  ) u_mix_datapath (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dry_in   (dry_in),
    .tap_in   (tap_in),
    .g        (g),
    .run      (run),
    .mix_out  (mix_out),
    .out_valid(out_valid)
  );

endmodule

// File: tb/tb_delay_tap_mixer.sv
// Directed bench for delay_tap_mixer with hand-computed expectations.
module tb_delay_tap_mixer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] dry_in;
  logic [7:0] tap_in;
  logic [1:0] tap_sel;
  logic [3:0] gain;
  logic [7:0] mix_out;
  logic       out_valid;
  logic       settle_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  delay_tap_mixer #(
    .WIDTH (8),
    .DEPTH0(30),
    .DEPTH1(45),
    .DEPTH2(60),
    .DEPTH3(90)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dry_in     (dry_in),
    .tap_in     (tap_in),
    .tap_sel    (tap_sel),
    .gain       (gain),
    .mix_out    (mix_out),
    .out_valid  (out_valid),
    .settle_busy(settle_busy)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; tap_sel = 2'd0; gain = 4'd8; dry_in = 8'd0; tap_in = 8'd0;
    step(1);
    check("rst_mix", 32'(mix_out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(settle_busy), 32'd1);

    rst = 1'b0; dry_in = 8'd10; tap_in = 8'd77;
    step(29);
    check("fill0_busy_29", 32'(settle_busy), 32'd1);
    check("fill0_mix_dry", 32'(mix_out), 32'd10);
    check("fill0_valid", 32'(out_valid), 32'd0);
    step(1);
    check("fill0_busy_30", 32'(settle_busy), 32'd0);
    step(1);
    check("run_valid_lag1", 32'(out_valid), 32'd0);
    step(1);
    check("run_valid_lag2", 32'(out_valid), 32'd1);
    check("run_mix_tap", 32'(mix_out), 32'd77);

    tap_in = 8'd200;
    step(1);
    check("lat_1cyc", 32'(mix_out), 32'd77);
    step(1);
    check("lat_2cyc", 32'(mix_out), 32'd200);

    gain = 4'd4; dry_in = 8'd200; tap_in = 8'd101;
    step(2);
    check("gain4_mix", 32'(mix_out), 32'd151);

    gain = 4'd15; dry_in = 8'd13; tap_in = 8'd250;
    step(2);
    check("gain15_clamp", 32'(mix_out), 32'd250);
    gain = 4'd8;
    step(2);
    check("gain8_same", 32'(mix_out), 32'd250);

    gain = 4'd0; dry_in = 8'd255; tap_in = 8'd0;
    step(2);
    check("gain0_dry", 32'(mix_out), 32'd255);

    gain = 4'd3; dry_in = 8'd100; tap_in = 8'd50;
    step(2);
    check("gain3_round", 32'(mix_out), 32'd81);

    gain = 4'd2; dry_in = 8'd1; tap_in = 8'd2;
    step(2);
    check("gain2_round", 32'(mix_out), 32'd1);

    // Switch 0 -> 3 while in RUN.
    gain = 4'd8; dry_in = 8'd40; tap_in = 8'd90; tap_sel = 2'd3;
    step(1);
    check("sw3_busy_now", 32'(settle_busy), 32'd1);
    step(1);
    check("sw3_valid_lag1", 32'(out_valid), 32'd1);
    step(1);
    check("sw3_valid_drop", 32'(out_valid), 32'd0);
    check("sw3_mix_dry", 32'(mix_out), 32'd40);
    step(87);
    check("sw3_busy_89", 32'(settle_busy), 32'd1);
    check("sw3_mix_dry_end", 32'(mix_out), 32'd40);
    step(1);
    check("sw3_busy_90", 32'(settle_busy), 32'd0);

    // Switch 3 -> 1, then 1 -> 2 when the count has reached 20.
    tap_sel = 2'd1;
    step(1);
    check("sw1_busy", 32'(settle_busy), 32'd1);
    step(25);
    tap_sel = 2'd2;
    step(1);
    check("sw2_busy", 32'(settle_busy), 32'd1);
    step(20);

    en = 1'b0; dry_in = 8'd99;
    step(10);
    check("freeze_busy", 32'(settle_busy), 32'd1);
    check("freeze_mix", 32'(mix_out), 32'd40);
    check("freeze_valid", 32'(out_valid), 32'd0);
    en = 1'b1;
    step(2);
    check("unfreeze_mix", 32'(mix_out), 32'd99);
    step(37);
    check("sw2_busy_59", 32'(settle_busy), 32'd1);
    step(1);
    check("sw2_busy_60", 32'(settle_busy), 32'd0);
    step(2);
    check("sw2_valid", 32'(out_valid), 32'd1);

    // Reset mid-RUN with en low.
    rst = 1'b1; en = 1'b0;
    step(1);
    check("rst2_mix", 32'(mix_out), 32'd0);
    check("rst2_valid", 32'(out_valid), 32'd0);
    check("rst2_busy", 32'(settle_busy), 32'd1);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
